debug_run_ctrl: RTL and testbench
=================================

DEBUG_RUN_CTRL -- requirements
Module: debug_run_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have host command ports: cmd_valid in 1; cmd_ready out 1; cmd_op in 3 (opcode); cmd_addr in 4 (word address); cmd_data in 8 (load word).
REQ-004 SHALL have CPU-side ports: cpu_fetch in 1 (IR-load cycle); cpu_pc in 4 (address being fetched); cpu_halt in 1; cpu_en out 1 (controller advance enable); cpu_rst out 1 (CPU reset pulse).
REQ-005 SHALL have instruction-memory write ports: im_we out 1; im_waddr out 4; im_wdata out 8.
REQ-006 SHALL have status ports: run_state out 2; bp_hit out 1 (sticky); cmd_err out 1 (one-cycle pulse); instr_count out 8.

Function
REQ-007 SHALL accept a command on any rising edge where cmd_valid=1 and cmd_ready=1.
REQ-008 cmd_op codes SHALL be: 0 NOP, 1 RUN, 2 STOP, 3 STEP, 4 LOAD, 5 SETBP, 6 CLRBP, 7 CPURST.
REQ-009 run_state SHALL encode: 0 STOPPED, 1 RUN, 2 STEP, 3 HALTED.
REQ-010 cmd_ready SHALL be 0 in STEP and 1 in all other states.
REQ-011 cpu_en SHALL be 1 only in RUN and STEP.
REQ-012 STOPPED: RUN -> RUN and clears bp_hit; STEP -> STEP and clears bp_hit; other ops execute with no state change.
REQ-013 RUN: STOP -> STOPPED; SETBP/CLRBP execute; NOP ignored; RUN, STEP, LOAD and CPURST SHALL be dropped and pulse cmd_err for one cycle.
REQ-014 STEP: on the first cpu_fetch=1 sampled in STEP -> STOPPED; cpu_en is therefore 0 from the following cycle.
REQ-015 Breakpoint: in RUN, cpu_fetch=1 with bp_valid=1 and cpu_pc==bp_addr -> STOPPED and set bp_hit. STEP SHALL ignore breakpoints.
REQ-016 cpu_halt=1 sampled in RUN or STEP -> HALTED. If halt and breakpoint or step-end occur in the same cycle, HALTED SHALL win and bp_hit is not set.
REQ-017 HALTED: only CPURST leaves it (-> STOPPED); RUN and STEP SHALL pulse cmd_err; LOAD, SETBP and CLRBP execute.
REQ-018 LOAD SHALL assert im_we for exactly the cycle after acceptance, with im_waddr=cmd_addr and im_wdata=cmd_data registered; the outputs hold their values otherwise, and im_we=0 at all other times.
REQ-019 LOAD SHALL also clear instr_count.
REQ-020 SETBP SHALL register bp_addr=cmd_addr and set bp_valid. CLRBP SHALL clear bp_valid.
REQ-021 CPURST SHALL drive cpu_rst=1 for exactly the cycle after acceptance, clear instr_count and bp_hit, and go to STOPPED.
REQ-022 instr_count SHALL increment on each cycle with cpu_en=1 and cpu_fetch=1, saturate at 255 (no wrap), and count the breakpoint fetch.
REQ-023 cpu_fetch and cpu_halt SHALL be ignored when cpu_en=0.
REQ-024 Back-to-back commands on consecutive cycles SHALL each be accepted; two LOADs SHALL give two consecutive im_we pulses.

Reset
REQ-025 While rst=1, the block SHALL hold: STOPPED, cpu_en=0, cmd_ready=1, cpu_rst=1, im_we=0, im_waddr=0, im_wdata=0, bp_valid=0, bp_addr=0, bp_hit=0, cmd_err=0, instr_count=0.
REQ-026 Reset asserted mid-STEP or mid-LOAD SHALL abort the operation with no im_we issued.
REQ-027 The first rising edge after rst deasserts SHALL drive cpu_rst=0.

Structure
REQ-028 The cmd_op and run_state encodings SHALL be defined as named constants in a shared package, dbg_pkg.
REQ-029 The block SHALL be a single module with one sub-module, sat_counter8 (the saturating instr_count counter).
REQ-030 All outputs SHALL be registered, except cmd_ready and cpu_en, which SHALL be decoded from state.

Verification
REQ-031 Scenario: reset, then LOAD addr=3 data=8'hA5 -> im_we=1 exactly one cycle later with im_waddr=3 and im_wdata=A5.
REQ-032 Scenario: SETBP addr=5, RUN, fetches at PC 0..5 -> STOPPED the cycle after the PC=5 fetch, bp_hit=1, instr_count=6.
REQ-033 Scenario: STEP from STOPPED -> cpu_en high until the first fetch, then STOPPED; cmd_ready=0 throughout STEP; instr_count +1.
REQ-034 Scenario: in RUN, issue LOAD -> cmd_err one-cycle pulse, im_we stays 0, state stays RUN.
REQ-035 Scenario: cpu_halt and breakpoint fetch in the same cycle -> HALTED, bp_hit=0; then RUN -> cmd_err; then CPURST -> cpu_rst pulse, STOPPED, instr_count=0.
REQ-036 Scenario: RUN a 260-fetch loop -> instr_count saturates at 255; rst asserted mid-run -> all REQ-025 values immediately.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared encodings for the debug run controller: host command opcodes,
// run states and datapath widths.
package dbg_pkg;

   typedef enum logic [2:0] {
      OP_NOP    = 3'd0,
      OP_RUN    = 3'd1,
      OP_STOP   = 3'd2,
      OP_STEP   = 3'd3,
      OP_LOAD   = 3'd4,
      OP_SETBP  = 3'd5,
      OP_CLRBP  = 3'd6,
      OP_CPURST = 3'd7
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUN     = 2'd1,
      ST_STEP    = 2'd2,
      ST_HALTED  = 2'd3
   } run_state_e;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 8;

endpackage

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 255 instead of wrapping; a synchronous
// clear takes priority over an increment.
module sat_counter8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, matching the hardware regardless of block order.
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != 8'hFF))
         count <= count + 8'd1;
   end

endmodule

// File: rtl/debug_run_ctrl.sv
// Debug run controller: accepts host commands to run, stop, single-step,
// load instruction memory and manage one breakpoint on a small CPU.
module debug_run_ctrl
   import dbg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic              cpu_fetch,
   input  logic [ADDR_W-1:0] cpu_pc,
   input  logic              cpu_halt,
   output logic              cpu_en,
   output logic              cpu_rst,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_waddr,
   output logic [DATA_W-1:0] im_wdata,
   output logic [1:0]        run_state,
   output logic              bp_hit,
   output logic              cmd_err,
   output logic [CNT_W-1:0]  instr_count
);

   run_state_e        state, state_nxt;
   cmd_op_e           op;
   logic              bp_valid;
   logic [ADDR_W-1:0] bp_addr;
   logic              cmd_acc, fetch_en, halt_en, bp_match;
   logic              do_load, do_setbp, do_clrbp, do_cpurst, do_err;
   logic              hit_set, hit_clr;

   assign op        = cmd_op_e'(cmd_op);
   assign cmd_ready = (state != ST_STEP);
   assign cpu_en    = (state == ST_RUN) || (state == ST_STEP);
   assign run_state = state;
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign fetch_en  = cpu_en && cpu_fetch;
   assign halt_en   = cpu_en && cpu_halt;
   assign bp_match  = (state == ST_RUN) && fetch_en && bp_valid && (cpu_pc == bp_addr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_STOPPED;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_nxt = state;
      do_load   = 1'b0;
      do_setbp  = 1'b0;
      do_clrbp  = 1'b0;
      do_cpurst = 1'b0;
      do_err    = 1'b0;
      hit_set   = 1'b0;
      hit_clr   = 1'b0;
      if (cmd_acc) begin
         case (state)
            ST_STOPPED: begin
               case (op)
                  OP_RUN:    begin state_nxt = ST_RUN;  hit_clr = 1'b1; end
                  OP_STEP:   begin state_nxt = ST_STEP; hit_clr = 1'b1; end
                  OP_LOAD:   do_load   = 1'b1;
                  OP_SETBP:  do_setbp  = 1'b1;
                  OP_CLRBP:  do_clrbp  = 1'b1;
                  OP_CPURST: do_cpurst = 1'b1;
                  default:   ;
               endcase
            end
            ST_RUN: begin
               case (op)
                  OP_STOP:  state_nxt = ST_STOPPED;
                  OP_SETBP: do_setbp  = 1'b1;
                  OP_CLRBP: do_clrbp  = 1'b1;
                  OP_NOP:   ;
                  default:  do_err    = 1'b1;
               endcase
            end
            ST_HALTED: begin
               case (op)
                  OP_CPURST:       begin do_cpurst = 1'b1; state_nxt = ST_STOPPED; end
                  OP_RUN, OP_STEP: do_err   = 1'b1;
                  OP_LOAD:         do_load  = 1'b1;
                  OP_SETBP:        do_setbp = 1'b1;
                  OP_CLRBP:        do_clrbp = 1'b1;
                  default:         ;
               endcase
            end
            default: ;
         endcase
      end
      if (do_cpurst)
         hit_clr = 1'b1;
      // CPU events override a concurrent STOP; halt beats step-end and breakpoint.
      if (halt_en)
         state_nxt = ST_HALTED;
      else if ((state == ST_STEP) && fetch_en)
         state_nxt = ST_STOPPED;
      else if (bp_match) begin
         state_nxt = ST_STOPPED;
         hit_set   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_rst  <= 1'b1;
         im_we    <= 1'b0;
         im_waddr <= '0;
         im_wdata <= '0;
         bp_valid <= 1'b0;
         bp_addr  <= '0;
         bp_hit   <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         cpu_rst <= do_cpurst;
         im_we   <= do_load;
         cmd_err <= do_err;
         if (do_load) begin
            im_waddr <= cmd_addr;
            im_wdata <= cmd_data;
         end
         if (do_setbp) begin
            bp_valid <= 1'b1;
            bp_addr  <= cmd_addr;
         end else if (do_clrbp) begin
            bp_valid <= 1'b0;
         end
         if (hit_set)      bp_hit <= 1'b1;
         else if (hit_clr) bp_hit <= 1'b0;
      end
   end

   sat_counter8 u_instr_count (
      .clk   (clk),
      .rst   (rst),
      .clr   (do_load || do_cpurst),
      .inc   (fetch_en),
      .count (instr_count)
   );

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl: a rule-level reference model checked
// on every falling edge, plus directed scenarios with literal expectations.
module tb_debug_run_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [3:0] cmd_addr = 4'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       cpu_fetch = 1'b0;
   logic [3:0] cpu_pc = 4'd0;
   logic       cpu_halt = 1'b0;
   logic       cpu_en, cpu_rst, im_we;
   logic [3:0] im_waddr;
   logic [7:0] im_wdata;
   logic [1:0] run_state;
   logic       bp_hit, cmd_err;
   logic [7:0] instr_count;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   debug_run_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cpu_fetch(cpu_fetch), .cpu_pc(cpu_pc), .cpu_halt(cpu_halt),
      .cpu_en(cpu_en), .cpu_rst(cpu_rst),
      .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
      .run_state(run_state), .bp_hit(bp_hit), .cmd_err(cmd_err),
      .instr_count(instr_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: states 0 stopped, 1 run, 2 step, 3 halted.
   // illegal[state] has bit op set when that op is rejected with an error.
   bit [7:0] illegal [4] = '{8'h00, 8'h9A, 8'h00, 8'h0A};
   int       m_st = 0, m_nst, m_cnt = 0;
   bit       m_hit = 0, m_err = 0, m_we = 0, m_crst = 1, m_bpv = 0, m_en;
   bit       old_bpv;
   bit [3:0] m_wa = 0, m_bpa = 0, old_bpa;
   bit [7:0] m_wd = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st = 0; m_cnt = 0; m_hit = 0; m_err = 0; m_we = 0; m_crst = 1;
         m_bpv = 0; m_bpa = 0; m_wa = 0; m_wd = 0;
      end else begin
         m_en = (m_st == 1) || (m_st == 2);
         old_bpv = m_bpv;
         old_bpa = m_bpa;
         m_nst = m_st; m_we = 0; m_err = 0; m_crst = 0;
         if (m_en && cpu_fetch && m_cnt < 255) m_cnt = m_cnt + 1;
         if (cmd_valid && m_st != 2) begin
            if (illegal[m_st][cmd_op]) m_err = 1;
            else case (cmd_op)
               3'd1: begin m_nst = 1; m_hit = 0; end
               3'd2: if (m_st == 1) m_nst = 0;
               3'd3: begin m_nst = 2; m_hit = 0; end
               3'd4: begin m_we = 1; m_wa = cmd_addr; m_wd = cmd_data; m_cnt = 0; end
               3'd5: begin m_bpv = 1; m_bpa = cmd_addr; end
               3'd6: m_bpv = 0;
               3'd7: begin m_crst = 1; m_cnt = 0; m_hit = 0; m_nst = 0; end
               default: ;
            endcase
         end
         if (m_en && cpu_halt) m_nst = 3;
         else if (m_en && cpu_fetch && m_st == 2) m_nst = 0;
         else if (m_en && cpu_fetch && m_st == 1 && old_bpv && cpu_pc == old_bpa) begin
            m_nst = 0;
            m_hit = 1;
         end
         m_st = m_nst;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("run_state",   run_state,   m_st);
         check("cmd_ready",   cmd_ready,   m_st != 2);
         check("cpu_en",      cpu_en,      m_st == 1 || m_st == 2);
         check("cpu_rst",     cpu_rst,     m_crst);
         check("im_we",       im_we,       m_we);
         check("im_waddr",    im_waddr,    m_wa);
         check("im_wdata",    im_wdata,    m_wd);
         check("bp_hit",      bp_hit,      m_hit);
         check("cmd_err",     cmd_err,     m_err);
         check("instr_count", instr_count, m_cnt);
      end
   end

   task automatic send(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] data);
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      @(posedge clk); #2;
      cmd_valid = 1'b0; cmd_op = 3'd0;
   endtask

   task automatic fetch(input logic [3:0] pc, input logic halt);
      cpu_fetch = 1'b1; cpu_pc = pc; cpu_halt = halt;
      @(posedge clk); #2;
      cpu_fetch = 1'b0; cpu_halt = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, ".run_state"}, run_state, 0);
      check({tag, ".cpu_en"}, cpu_en, 0);
      check({tag, ".cmd_ready"}, cmd_ready, 1);
      check({tag, ".cpu_rst"}, cpu_rst, 1);
      check({tag, ".im_we"}, im_we, 0);
      check({tag, ".im_waddr"}, im_waddr, 0);
      check({tag, ".im_wdata"}, im_wdata, 0);
      check({tag, ".bp_hit"}, bp_hit, 0);
      check({tag, ".cmd_err"}, cmd_err, 0);
      check({tag, ".instr_count"}, instr_count, 0);
   endtask

   initial begin
      #1 chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check_reset_values("reset");
      rst = 1'b0;
      idle(1);
      check("rel.cpu_rst", cpu_rst, 0);

      // LOAD addr 3 data A5, then back-to-back LOADs
      send(3'd4, 4'd3, 8'hA5);
      check("load.im_we", im_we, 1);
      check("load.im_waddr", im_waddr, 3);
      check("load.im_wdata", im_wdata, 8'hA5);
      idle(1);
      check("load.we_drop", im_we, 0);
      check("load.hold", im_wdata, 8'hA5);
      send(3'd4, 4'd1, 8'h11);
      check("b2b.we1", im_we, 1);
      send(3'd4, 4'd2, 8'h22);
      check("b2b.we2", im_we, 1);
      check("b2b.addr2", im_waddr, 2);
      idle(1);

      // breakpoint at 5, run through PC 0..5
      send(3'd5, 4'd5, 8'h00);
      send(3'd1, 4'd0, 8'h00);
      check("run.state", run_state, 1);
      for (int i = 0; i < 6; i++) fetch(4'(i), 1'b0);
      check("bp.state", run_state, 0);
      check("bp.hit", bp_hit, 1);
      check("bp.count", instr_count, 6);

      // single step: breakpoint ignored, exactly one fetch counted
      send(3'd3, 4'd0, 8'h00);
      check("step.state", run_state, 2);
      check("step.ready", cmd_ready, 0);
      check("step.en", cpu_en, 1);
      check("step.hit_clr", bp_hit, 0);
      idle(2);
      fetch(4'd5, 1'b0);
      check("step.end", run_state, 0);
      check("step.en_off", cpu_en, 0);
      check("step.count", instr_count, 7);

      // illegal commands while running
      send(3'd1, 4'd0, 8'h00);
      send(3'd4, 4'd9, 8'h77);
      check("runload.err", cmd_err, 1);
      check("runload.we", im_we, 0);
      check("runload.state", run_state, 1);
      idle(1);
      check("runload.err_pulse", cmd_err, 0);
      send(3'd1, 4'd0, 8'h00);
      send(3'd3, 4'd0, 8'h00);
      send(3'd7, 4'd0, 8'h00);
      idle(1);
      fetch(4'd2, 1'b0);

      // halt coincides with breakpoint fetch
      fetch(4'd5, 1'b1);
      check("halt.state", run_state, 3);
      check("halt.hit", bp_hit, 0);
      send(3'd1, 4'd0, 8'h00);
      check("halt.run_err", cmd_err, 1);
      send(3'd4, 4'd6, 8'h3C);
      check("halt.load", im_we, 1);
      fetch(4'd5, 1'b1);
      send(3'd7, 4'd0, 8'h00);
      check("cpurst.pulse", cpu_rst, 1);
      check("cpurst.state", run_state, 0);
      check("cpurst.count", instr_count, 0);
      idle(1);
      check("cpurst.drop", cpu_rst, 0);
      fetch(4'd5, 1'b1);
      check("stopped.ignore", run_state, 0);

      // RUN then STOP
      send(3'd1, 4'd0, 8'h00);
      send(3'd2, 4'd0, 8'h00);
      check("stop.state", run_state, 0);

      // saturation over a long loop, then reset mid-run
      send(3'd6, 4'd0, 8'h00);
      send(3'd1, 4'd0, 8'h00);
      for (int i = 0; i < 260; i++) fetch(4'(i), 1'b0);
      check("sat.count", instr_count, 255);
      check("sat.state", run_state, 1);
      rst = 1'b1;
      #1;
      check_reset_values("midrun");
      idle(2);
      rst = 1'b0;
      idle(1);

      // reset during STEP and during a LOAD handshake
      send(3'd3, 4'd0, 8'h00);
      check("mstep.state", run_state, 2);
      rst = 1'b1;
      #1;
      check("mstep.state_rst", run_state, 0);
      check("mstep.en", cpu_en, 0);
      idle(1);
      rst = 1'b0;
      idle(1);
      cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 4'd7; cmd_data = 8'hEE;
      #1 rst = 1'b1;
      @(posedge clk); #2;
      cmd_valid = 1'b0; cmd_op = 3'd0;
      check("mload.we", im_we, 0);
      idle(1);
      check("mload.we2", im_we, 0);
      rst = 1'b0;
      idle(2);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
